// File: rtl/mshr_pkg.sv
// rtl/mshr_pkg.sv - shared entry state encoding and decode helpers for the MSHR
package mshr_pkg;

  typedef enum logic [1:0] {
    ST_FREE       = 2'd0,
    ST_WAIT_ISSUE = 2'd1,
    ST_WAIT_FILL  = 2'd2,
    ST_REPLAY     = 2'd3
  } entry_state_e;

  // Only entries whose fetch is still outstanding may accept merged targets.
  function automatic logic is_pending(input entry_state_e s);
    return (s == ST_WAIT_ISSUE) || (s == ST_WAIT_FILL);
  endfunction

endpackage

// File: rtl/mshr_free_list.sv
// rtl/mshr_free_list.sv - lowest-index FREE entry selection and full/empty decode
module mshr_free_list #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]    free_vec,
  output logic [TAG_BITS-1:0] free_idx,
  output logic                full,
  output logic                empty
);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = TAG_BITS'(i);
    end
  end

  assign full  = ~|free_vec;
  assign empty = &free_vec;

endmodule

// File: rtl/mshr_merge.sv
// rtl/mshr_merge.sv - miss status holding registers with same-line request merging
// MSHR_MERGE_EN enables merging of up to TGT_MAX targets per entry; otherwise one target per entry.
module mshr_merge
  import mshr_pkg::*;
#(
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 90,
  parameter int CPU_ID_BITS = 2,
  parameter int LINE_BITS   = 5,
  parameter int DEPTH       = 8,
  parameter int TGT_MAX     = 4,
  parameter int TAG_BITS    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_BITS-1:0]           req_addr,
  input  logic [DATA_BITS-1:0]           req_data,
  input  logic                           req_rw,
  input  logic [CPU_ID_BITS-1:0]         req_cpu_id,
  output logic                           req_primary,
  output logic [TAG_BITS-1:0]            req_tag,
  output logic                           mem_valid,
  input  logic                           mem_ready,
  output logic [ADDR_BITS-LINE_BITS-1:0] mem_addr,
  output logic [TAG_BITS-1:0]            mem_tag,
  input  logic                           fill_valid,
  input  logic [TAG_BITS-1:0]            fill_tag,
  output logic                           rep_valid,
  input  logic                           rep_ready,
  output logic [ADDR_BITS-1:0]           rep_addr,
  output logic [DATA_BITS-1:0]           rep_data,
  output logic                           rep_rw,
  output logic [CPU_ID_BITS-1:0]         rep_cpu_id,
  output logic [TAG_BITS-1:0]            rep_tag,
  output logic                           full,
  output logic                           empty
);

  localparam int LINE_W = ADDR_BITS - LINE_BITS;
`ifdef MSHR_MERGE_EN
  localparam int TGT_EFF = TGT_MAX;
`else
  localparam int TGT_EFF = (TGT_MAX > 0) ? 1 : 1;
`endif
  localparam int CW = $clog2(TGT_EFF) + 1;
  localparam int SW = (TGT_EFF > 1) ? $clog2(TGT_EFF) : 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0]   addr;
    logic [DATA_BITS-1:0]   data;
    logic                   rw;
    logic [CPU_ID_BITS-1:0] cpu_id;
  } target_t;

  entry_state_e      state [DEPTH];
  logic [LINE_W-1:0] line  [DEPTH];
  logic [CW-1:0]     cnt   [DEPTH];
  logic [CW-1:0]     rptr  [DEPTH];
  target_t           tgt   [DEPTH][TGT_EFF];

  logic [LINE_W-1:0]   req_line;
  logic [DEPTH-1:0]    free_vec, pend_hit, rep_hit, issue_vec, replay_vec;
  logic [TAG_BITS-1:0] free_idx, match_idx, issue_idx, rep_idx;
  logic                match_any, accept, alloc;
  logic                mem_lock, issue_fire, rep_fire, rep_last;
  logic [TAG_BITS-1:0] lock_tag;
  target_t             req_t, rep_t;

  assign req_line = req_addr[ADDR_BITS-1:LINE_BITS];
  assign req_t    = '{addr: req_addr, data: req_data, rw: req_rw, cpu_id: req_cpu_id};

  always_comb begin
    match_idx = '0;
    issue_idx = '0;
    rep_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_vec[i]   = (state[i] == ST_FREE);
      pend_hit[i]   = is_pending(state[i]) && (line[i] == req_line);
      rep_hit[i]    = (state[i] == ST_REPLAY) && (line[i] == req_line);
      issue_vec[i]  = (state[i] == ST_WAIT_ISSUE);
      replay_vec[i] = (state[i] == ST_REPLAY);
      if (pend_hit[i])   match_idx = TAG_BITS'(i);
      if (issue_vec[i])  issue_idx = TAG_BITS'(i);
      if (replay_vec[i]) rep_idx   = TAG_BITS'(i);
    end
  end

  mshr_free_list #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS)) u_free_list (
    .free_vec (free_vec),
    .free_idx (free_idx),
    .full     (full),
    .empty    (empty)
  );

  assign match_any = |pend_hit;

  // A line still being replayed blocks new requests so replay order cannot be overtaken.
`ifdef MSHR_MERGE_EN
  logic merge;
  assign req_ready   = !(|rep_hit) && (match_any ? (cnt[match_idx] < CW'(TGT_EFF)) : !full);
  assign req_primary = !match_any;
  assign merge       = accept && match_any;
`else
  assign req_ready   = !(|rep_hit) && !match_any && !full;
  assign req_primary = 1'b1;
`endif
  assign req_tag = match_any ? match_idx : free_idx;
  assign accept  = req_valid && req_ready;
  assign alloc   = accept && !match_any;

  // Once offered, the fetch is pinned so a lower entry allocated meanwhile cannot swap it out.
  assign mem_tag    = mem_lock ? lock_tag : issue_idx;
  assign mem_valid  = mem_lock || (|issue_vec);
  assign mem_addr   = line[mem_tag];
  assign issue_fire = mem_valid && mem_ready;

  assign rep_valid  = |replay_vec;
  assign rep_tag    = rep_idx;
  assign rep_t      = tgt[rep_idx][rptr[rep_idx][SW-1:0]];
  assign rep_addr   = rep_t.addr;
  assign rep_data   = rep_t.data;
  assign rep_rw     = rep_t.rw;
  assign rep_cpu_id = rep_t.cpu_id;
  assign rep_fire   = rep_valid && rep_ready;
  assign rep_last   = (rptr[rep_idx] + CW'(1)) == cnt[rep_idx];

  // Alloc, issue, fill and replay each act on an entry in a different state, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= ST_FREE;
        line[i]  <= '0;
        cnt[i]   <= '0;
        rptr[i]  <= '0;
      end
      mem_lock <= 1'b0;
      lock_tag <= '0;
    end else begin
      if (alloc) begin
        state[free_idx] <= ST_WAIT_ISSUE;
        line[free_idx]  <= req_line;
        cnt[free_idx]   <= CW'(1);
        rptr[free_idx]  <= '0;
      end
`ifdef MSHR_MERGE_EN
      if (merge) cnt[match_idx] <= cnt[match_idx] + CW'(1);
`endif
      if (issue_fire) state[mem_tag] <= ST_WAIT_FILL;
      if (fill_valid && (state[fill_tag] == ST_WAIT_FILL)) state[fill_tag] <= ST_REPLAY;
      if (rep_fire) begin
        if (rep_last) begin
          state[rep_idx] <= ST_FREE;
          cnt[rep_idx]   <= '0;
          rptr[rep_idx]  <= '0;
        end else begin
          rptr[rep_idx] <= rptr[rep_idx] + CW'(1);
        end
      end
      if (issue_fire) begin
        mem_lock <= 1'b0;
      end else if (mem_valid) begin
        mem_lock <= 1'b1;
        lock_tag <= mem_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) tgt[free_idx][0] <= req_t;
`ifdef MSHR_MERGE_EN
    if (merge) tgt[match_idx][cnt[match_idx][SW-1:0]] <= req_t;
`endif
  end

endmodule

// File: tb/tb_mshr_merge.sv
// tb/tb_mshr_merge.sv - scoreboard bench for mshr_merge; merge scenarios run when MSHR_MERGE_EN is defined
module tb_mshr_merge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_addr = '0;
  logic [89:0] req_data = '0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_cpu_id = '0;
  logic        req_primary;
  logic [2:0]  req_tag;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [14:0] mem_addr;
  logic [2:0]  mem_tag;
  logic        fill_valid = 1'b0;
  logic [2:0]  fill_tag = '0;
  logic        rep_valid;
  logic        rep_ready = 1'b1;
  logic [19:0] rep_addr;
  logic [89:0] rep_data;
  logic        rep_rw;
  logic [1:0]  rep_cpu_id;
  logic [2:0]  rep_tag;
  logic        full;
  logic        empty;

  mshr_merge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .req_cpu_id(req_cpu_id), .req_primary(req_primary), .req_tag(req_tag),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_tag(mem_tag),
    .fill_valid(fill_valid), .fill_tag(fill_tag),
    .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_addr(rep_addr), .rep_data(rep_data),
    .rep_rw(rep_rw), .rep_cpu_id(rep_cpu_id), .rep_tag(rep_tag),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic [89:0] data;
    logic        rw;
    logic [1:0]  id;
    logic [2:0]  tag;
  } rep_exp_t;

  logic [3:0]  exp_req [$];
  logic [17:0] exp_mem [$];
  rep_exp_t    exp_rep [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  function automatic logic [89:0] data_of(input logic [19:0] a);
    return {a, a, a, 30'h1234_5678 ^ 30'(a)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [19:0] a, input logic rw, input logic [1:0] id,
                           input logic prim, input logic [2:0] tag);
    req_addr   = a;
    req_data   = data_of(a);
    req_rw     = rw;
    req_cpu_id = id;
    req_valid  = 1'b1;
    exp_req.push_back({prim, tag});
    exp_rep.push_back('{addr: a, data: data_of(a), rw: rw, id: id, tag: tag});
    if (prim) exp_mem.push_back({a[19:5], tag});
  endtask

  task automatic wait_accept(input string nm);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    fail_now({nm, " accept timeout"});
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [19:0] a, input logic rw, input logic [1:0] id,
                      input logic prim, input logic [2:0] tag);
    drive_req(a, rw, id, prim, tag);
    wait_accept("send");
  endtask

  task automatic fill(input logic [2:0] t);
    fill_valid = 1'b1;
    fill_tag   = t;
    @(posedge clk);
    #1;
    fill_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake the DUT completes.
  initial begin : monitor
    logic [3:0] er;
    logic [17:0] em;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (req_valid && req_ready) begin
          if (exp_req.size() == 0) fail_now("req handshake");
          else begin
            er = exp_req.pop_front();
            check("req primary/tag", {req_primary, req_tag}, er);
          end
        end
        if (mem_valid && mem_ready) begin
          if (exp_mem.size() == 0) fail_now("mem fetch");
          else begin
            em = exp_mem.pop_front();
            check("mem addr/tag", {mem_addr, mem_tag}, em);
          end
        end
        if (rep_valid && rep_ready) begin
          int idx = -1;
          for (int k = 0; k < exp_rep.size(); k++) begin
            if (exp_rep[k].tag == rep_tag) begin
              idx = k;
              break;
            end
          end
          if (idx < 0) fail_now("replay");
          else begin
            check("replay fields", {rep_addr, rep_data, rep_rw, rep_cpu_id, rep_tag}, exp_rep[idx]);
            exp_rep.delete(idx);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset empty", empty, 1'b1);
    check("reset full", full, 1'b0);
    check("reset mem_valid", mem_valid, 1'b0);
    check("reset rep_valid", rep_valid, 1'b0);
    reset = 1'b1;
    idle(1);
    check("reset req_ready", req_ready, 1'b1);

    // First request: allocates tag 0, fetch visible next cycle and held while not ready
    mem_ready = 1'b0;
    send(20'h01234, 1'b0, 2'd1, 1'b1, 3'd0);
    check("first mem_valid", mem_valid, 1'b1);
    check("first mem_addr", mem_addr, 15'h091);
    check("first mem_tag", mem_tag, 3'd0);
    check("first empty", empty, 1'b0);
    idle(2);
    check("held mem_addr", {mem_valid, mem_addr}, {1'b1, 15'h091});
    mem_ready = 1'b1;
    idle(1);
    fill(3'd0);
    idle(3);
    check("first drained empty", empty, 1'b1);

    // Fill to a FREE entry is ignored
    fill(3'd5);
    idle(1);
    check("fill free empty", empty, 1'b1);
    check("fill free rep_valid", rep_valid, 1'b0);

    // Eight distinct lines fill the table; ninth stalls until tag 3 retires
    for (int i = 0; i < 8; i++) send(20'h10000 + 20'(i << 5), 1'(i), 2'(i), 1'b1, 3'(i));
    idle(2);
    check("eight full", full, 1'b1);
    drive_req(20'h20000, 1'b1, 2'd3, 1'b1, 3'd3);
    idle(3);
    check("ninth stalls", req_ready, 1'b0);
    fill(3'd3);
    wait_accept("ninth");
    idle(2);
    check("ninth full again", full, 1'b1);
    for (int i = 0; i < 8; i++) fill(3'(i));
    idle(12);
    check("eight drained empty", empty, 1'b1);

    // Reset during WAIT_FILL discards the entry; later fill is ignored
    send(20'h05000, 1'b0, 2'd2, 1'b1, 3'd0);
    idle(2);
    reset = 1'b0;
    exp_rep.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
    check("post reset empty", empty, 1'b1);
    check("post reset req_ready", req_ready, 1'b1);
    fill(3'd0);
    idle(2);
    check("late fill empty", empty, 1'b1);
    check("late fill rep_valid", rep_valid, 1'b0);

`ifdef MSHR_MERGE_EN
    // Three requests to one line: one fetch, three ordered replays
    send(20'h01234, 1'b0, 2'd0, 1'b1, 3'd0);
    send(20'h01238, 1'b1, 2'd1, 1'b0, 3'd0);
    send(20'h0123C, 1'b0, 2'd2, 1'b0, 3'd0);
    idle(2);
    fill(3'd0);
    idle(5);
    check("merge3 empty", empty, 1'b1);

    // Fifth request to a line already holding TGT_MAX targets waits for full retirement
    for (int i = 0; i < 4; i++) send(20'h03000 + 20'(i * 4), 1'(i), 2'(i), (i == 0), 3'd0);
    drive_req(20'h03010, 1'b1, 2'd3, 1'b1, 3'd0);
    idle(3);
    check("fifth stalls", req_ready, 1'b0);
    fill(3'd0);
    check("fifth stalls replay", req_ready, 1'b0);
    wait_accept("fifth");
    idle(2);
    fill(3'd0);
    idle(3);
    check("fifth drained empty", empty, 1'b1);

    // Merge in the same cycle the fill lands is still replayed
    send(20'h04000, 1'b0, 2'd1, 1'b1, 3'd0);
    idle(2);
    drive_req(20'h04008, 1'b1, 2'd2, 1'b0, 3'd0);
    fill_valid = 1'b1;
    fill_tag   = 3'd0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    fill_valid = 1'b0;
    idle(4);
    check("fill-merge empty", empty, 1'b1);
`else
    // Without merging, a second request to a pending line waits for the entry to free
    send(20'h01234, 1'b0, 2'd1, 1'b1, 3'd0);
    idle(2);
    drive_req(20'h01238, 1'b1, 2'd2, 1'b1, 3'd0);
    idle(2);
    check("nomerge stalls", req_ready, 1'b0);
    fill(3'd0);
    check("nomerge stalls replay", req_ready, 1'b0);
    wait_accept("nomerge second");
    idle(2);
    fill(3'd0);
    idle(3);
    check("nomerge drained empty", empty, 1'b1);
`endif

    idle(2);
    check("req scoreboard drained", exp_req.size(), 0);
    check("mem scoreboard drained", exp_mem.size(), 0);
    check("rep scoreboard drained", exp_rep.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mshr_merge.md
MSHR_MERGE -- requirements
Module: mshr_merge

Interface
REQ-001 Parameter ADDR_BITS, 20, byte address width.
REQ-002 Parameter DATA_BITS, 90, request payload width.
REQ-003 Parameter CPU_ID_BITS, 2, requester id width.
REQ-004 Parameter LINE_BITS, 5, line offset bits; line address = addr[ADDR_BITS-1:LINE_BITS].
REQ-005 Parameter DEPTH, 8, entry count, power of two >= 2; TAG_BITS = log2(DEPTH).
REQ-006 Parameter TGT_MAX, 4, merged targets per entry, >= 1.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 req_valid/req_ready  in/out  1/1  miss request handshake.
REQ-010 req_addr/req_data/req_rw/req_cpu_id  in  ADDR_BITS/DATA_BITS/1/CPU_ID_BITS  request fields.
REQ-011 req_primary/req_tag  out  1/TAG_BITS  combinational: new entry allocated (1) or merge (0); entry used.
REQ-012 mem_valid/mem_ready  out/in  1/1  line fetch handshake toward memory.
REQ-013 mem_addr/mem_tag  out  ADDR_BITS-LINE_BITS/TAG_BITS  fetched line address, entry tag.
REQ-014 fill_valid/fill_tag  in  1/TAG_BITS  fill return for an entry.
REQ-015 rep_valid/rep_ready  out/in  1/1  replay handshake toward cache pipeline.
REQ-016 rep_addr/rep_data/rep_rw/rep_cpu_id/rep_tag  out  as request fields, TAG_BITS  replayed target.
REQ-017 full/empty  out  1/1  no FREE entry / all entries FREE.

Function
REQ-018 Each entry SHALL hold state FREE, WAIT_ISSUE, WAIT_FILL or REPLAY, a line address, and a target queue of TGT_MAX slots in arrival order.
REQ-019 Match SHALL mean entry in WAIT_ISSUE or WAIT_FILL with equal line address; at most one entry matches.
REQ-020 No match and a FREE entry exists: accept, allocate lowest-index FREE entry into WAIT_ISSUE with target slot 0, req_primary=1.
REQ-021 Match with target count < TGT_MAX: accept, append target, req_primary=0, state unchanged.
REQ-022 req_ready SHALL be 0 when: match with count == TGT_MAX; line equals any REPLAY entry; or no match and no FREE entry.
REQ-023 mem_* SHALL present lowest-index WAIT_ISSUE entry; on mem_valid&&mem_ready entry goes to WAIT_FILL; entry allocated in cycle N is issuable no earlier than N+1; mem_valid held with stable fields until accepted.
REQ-024 fill_valid with fill_tag in WAIT_FILL SHALL move entry to REPLAY next cycle; fill to any other state SHALL be ignored.
REQ-025 Request merging into an entry in the same cycle its fill arrives SHALL be accepted and replayed.
REQ-026 rep_* SHALL present the oldest unreplayed target of lowest-index REPLAY entry; each rep handshake advances one target; after last target entry becomes FREE next cycle, reusable the cycle after.
REQ-027 Target counters SHALL be log2(TGT_MAX)+1 bits, never wrap; fill/issue/replay of different entries in one cycle all take effect.
REQ-028 full and empty SHALL be registered-state decodes, valid the same cycle as state.

Reset
REQ-029 On reset low: all entries FREE, counters zero, mem_valid=0, rep_valid=0, full=0, empty=1, req_ready=1 after release.
REQ-030 Reset mid-operation SHALL discard all entries; fills arriving after release SHALL be ignored.

Configuration
REQ-031 Macro MSHR_MERGE_EN defined: merging per REQ-021.
REQ-032 MSHR_MERGE_EN undefined: effective TGT_MAX=1, any match deasserts req_ready, req_primary always 1 on acceptance; target storage not built.

Structure
REQ-033 Package mshr_pkg SHALL hold entry-state enum and entry/target field typedefs.
REQ-034 Sub-module mshr_free_list SHALL provide lowest-index FREE selection and full/empty.

Verification
REQ-035 Reset, req 0x01234 -> req_primary=1, tag 0, mem_valid next cycle, mem_addr=0x091.
REQ-036 Three reqs to 0x01234/0x01238/0x0123C -> one mem fetch; fill tag 0 -> three replays in order, then empty=1.
REQ-037 Five reqs same line, TGT_MAX=4 -> fifth stalls req_ready=0 until fill and replays finish, then allocates fresh.
REQ-038 Eight distinct lines -> full=1, ninth distinct stalls; fill+replay tag 3 -> next alloc gets tag 3.
REQ-039 Fill to FREE tag 5 -> no state change; reset during WAIT_FILL then fill -> ignored, empty=1.
REQ-040 MSHR_MERGE_EN undefined: second req same line -> req_ready=0 until first entry freed.
